// File: rtl/slow_clk_monitor_pkg.sv
// Shared types and defaults for the slow-clock monitor and its edge detector.
package slow_clk_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam int HALF_PERIOD_DEF = 5000;
  localparam int TOL_DEF         = 4;
  localparam int LOCK_COUNT_DEF  = 4;
  localparam int CNT_W_DEF       = 26;

  // |m - target| <= tol, evaluated on the larger-minus-smaller side so the
  // unsigned subtraction can never wrap.
  function automatic logic within_tol(input logic [31:0] m,
                                      input logic [31:0] target,
                                      input logic [31:0] tol);
    logic [31:0] diff;
    if (m >= target) begin
      diff = m - target;
    end else begin
      diff = target - m;
    end
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/slow_clk_monitor_edge.sv
// Two-flop synchronizer with a history flop and registered rise/fall pulses.
// The combinational edge_det flags the cycle before the pulses register, so
// the parent can update its own state on the same clock edge as the pulse.
module sync_edge_detect
  import slow_clk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edge_det,
  output logic rise_tick,
  output logic fall_tick
);

  logic s1_r;
  logic s2_r;
  logic s3_r;
  logic rise_r;
  logic fall_r;
  logic edge_s;

  assign edge_s = s2_r ^ s3_r;

  // Synchronize the asynchronous input and register one-cycle edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      s3_r   <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      s1_r   <= din;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      rise_r <= edge_s & s2_r;
      fall_r <= edge_s & ~s2_r;
    end
  end

  assign edge_det  = edge_s;
  assign rise_tick = rise_r;
  assign fall_tick = fall_r;

endmodule

// File: rtl/slow_clk_monitor.sv
// Receives the divided slow clock as data, emits clk-domain edge enables,
// measures the half-period and tracks lock against the expected interval.
module slow_clk_monitor
  import slow_clk_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int TOL         = TOL_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MATCH_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST   = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(HALF_PERIOD + TOL + 1);

  logic               edge_s;
  logic               match_s;
  logic               timeout_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [MATCH_W-1:0] match_cnt_r;
  lock_state_t        state_r;
  logic [CNT_W-1:0]   half_period_r;
  logic               period_valid_r;
  logic               locked_r;
  logic               timeout_r;

  sync_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .din      (slow_clk_in),
    .edge_det (edge_s),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  // cnt is the measurement only in the cycle an edge is detected.
  assign match_s   = within_tol(32'(cnt_r), 32'(HALF_PERIOD), 32'(TOL));
  assign timeout_s = (cnt_r == TIMEOUT_CNT);

  // Interval counter: restarts at 1 on each edge, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (edge_s) begin
      cnt_r <= CNT_W'(1);
    end else if (cnt_r != '1) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Lock FSM with measurement and status registers; an edge always takes
  // priority over a timeout landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= UNLOCKED;
      match_cnt_r    <= '0;
      half_period_r  <= '0;
      period_valid_r <= 1'b0;
      locked_r       <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        UNLOCKED: begin
          // First edge only establishes a reference point.
          if (edge_s) begin
            state_r     <= ACQUIRE;
            match_cnt_r <= '0;
          end
        end
        ACQUIRE: begin
          if (edge_s) begin
            half_period_r  <= cnt_r;
            period_valid_r <= 1'b1;
            if (match_s) begin
              if (match_cnt_r == LOCK_LAST) begin
                state_r     <= LOCKED;
                locked_r    <= 1'b1;
                match_cnt_r <= '0;
              end else begin
                match_cnt_r <= match_cnt_r + MATCH_W'(1);
              end
            end else begin
              match_cnt_r <= '0;
            end
          end else if (timeout_s) begin
            state_r        <= UNLOCKED;
            locked_r       <= 1'b0;
            period_valid_r <= 1'b0;
            timeout_r      <= 1'b1;
            match_cnt_r    <= '0;
          end
        end
        LOCKED: begin
          if (edge_s) begin
            half_period_r  <= cnt_r;
            period_valid_r <= 1'b1;
            if (!match_s) begin
              state_r     <= ACQUIRE;
              locked_r    <= 1'b0;
              match_cnt_r <= '0;
            end
          end else if (timeout_s) begin
            state_r        <= UNLOCKED;
            locked_r       <= 1'b0;
            period_valid_r <= 1'b0;
            timeout_r      <= 1'b1;
            match_cnt_r    <= '0;
          end
        end
        default: begin
          state_r     <= UNLOCKED;
          locked_r    <= 1'b0;
          match_cnt_r <= '0;
        end
      endcase
    end
  end

  assign half_period  = half_period_r;
  assign period_valid = period_valid_r;
  assign locked       = locked_r;
  assign timeout      = timeout_r;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench: instance A uses small parameters for lock/timeout cases,
// instance B runs defaults fed by a divide-by-5000 toggle.
module tb_slow_clk_monitor;

  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic        slow_a, slow_b;
  logic        rise_a, fall_a, valid_a, locked_a, timeout_a;
  logic        rise_b, fall_b, valid_b, locked_b, timeout_b;
  logic [25:0] hp_a, hp_b;

  int n_checks = 0;
  int n_fail   = 0;
  int b_edges  = 0;
  int b_timeouts = 0;

  always #5 clk = ~clk;

  slow_clk_monitor #(.HALF_PERIOD(10), .TOL(1), .LOCK_COUNT(3), .CNT_W(26)) dut_a (
    .clk(clk), .reset(reset_a), .slow_clk_in(slow_a),
    .rise_tick(rise_a), .fall_tick(fall_a), .half_period(hp_a),
    .period_valid(valid_a), .locked(locked_a), .timeout(timeout_a)
  );

  slow_clk_monitor dut_b (
    .clk(clk), .reset(reset_b), .slow_clk_in(slow_b),
    .rise_tick(rise_b), .fall_tick(fall_b), .half_period(hp_b),
    .period_valid(valid_b), .locked(locked_b), .timeout(timeout_b)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Toggle slow_a, then spend gap cycles; the tick and status land 3 negedges
  // after the toggle. to_at (0 = never) is the cycle a timeout is expected.
  task automatic step_edge(input string tag, input int gap, input int to_at,
                           input logic [25:0] ehp, input logic ev, input logic el);
    slow_a = !slow_a;
    for (int j = 1; j <= gap; j++) begin
      @(negedge clk);
      if (j == 3) begin
        check_val({tag, " rise"}, rise_a, slow_a);
        check_val({tag, " fall"}, fall_a, !slow_a);
        check_val({tag, " half_period"}, hp_a, ehp);
        check_val({tag, " valid"}, valid_a, ev);
        check_val({tag, " locked"}, locked_a, el);
      end else begin
        check_val({tag, " no_tick"}, {rise_a, fall_a}, 2'b00);
      end
      check_val({tag, " timeout"}, timeout_a, (j == to_at));
    end
  endtask

  // Instance B stimulus: reset, then toggle every 5000 cycles.
  initial begin
    reset_b = 1'b1;
    slow_b  = 1'b0;
    repeat (3) @(negedge clk);
    reset_b = 1'b0;
    forever begin
      repeat (5000) @(negedge clk);
      slow_b = !slow_b;
    end
  end

  // Instance B checks at every tick.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_b) begin
        if (timeout_b) b_timeouts++;
        if (rise_b || fall_b) begin
          b_edges++;
          check_val("b rise_dir", rise_b, (b_edges % 2 == 1));
          check_val("b valid", valid_b, (b_edges >= 2));
          check_val("b half_period", hp_b, (b_edges >= 2) ? 64'd5000 : 64'd0);
          check_val("b locked", locked_b, (b_edges >= 5));
        end
      end
    end
  end

  // Instance A directed sequence and final summary.
  initial begin
    reset_a = 1'b1;
    slow_a  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slow_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("reset outs", {rise_a, fall_a, hp_a, valid_a, locked_a, timeout_a}, 64'd0);
    end
    slow_a  = 1'b0;
    reset_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("idle after reset", {rise_a, fall_a, timeout_a}, 3'b000);
    end

    // Acquire and lock at interval 10.
    step_edge("e1",  10, 0, 26'd0,  1'b0, 1'b0);
    step_edge("e2",  10, 0, 26'd10, 1'b1, 1'b0);
    step_edge("e3",  10, 0, 26'd10, 1'b1, 1'b0);
    step_edge("e4",  11, 0, 26'd10, 1'b1, 1'b1);
    // Tolerance edges, then out-of-tolerance, then relock.
    step_edge("e5",  9,  0, 26'd11, 1'b1, 1'b1);
    step_edge("e6",  12, 0, 26'd9,  1'b1, 1'b1);
    step_edge("e7",  10, 0, 26'd12, 1'b1, 1'b0);
    step_edge("e8",  10, 0, 26'd10, 1'b1, 1'b0);
    step_edge("e9",  10, 0, 26'd10, 1'b1, 1'b0);
    // Relock, then stop toggling: timeout 12 cycles after the tick.
    step_edge("e10", 20, 15, 26'd10, 1'b1, 1'b1);
    check_val("post timeout locked", locked_a, 1'b0);
    check_val("post timeout valid", valid_a, 1'b0);
    check_val("post timeout hp held", hp_a, 26'd10);
    // First edge after timeout: no measurement.
    step_edge("e11", 10, 0, 26'd10, 1'b0, 1'b0);
    step_edge("e12", 10, 0, 26'd10, 1'b1, 1'b0);
    step_edge("e13", 10, 0, 26'd10, 1'b1, 1'b0);
    step_edge("e14", 12, 0, 26'd10, 1'b1, 1'b1);
    // Edge exactly at the timeout count: mismatch, no timeout.
    step_edge("e15", 10, 0, 26'd12, 1'b1, 1'b0);
    step_edge("e16", 10, 0, 26'd10, 1'b1, 1'b0);
    step_edge("e17", 10, 0, 26'd10, 1'b1, 1'b0);
    step_edge("e18", 3,  0, 26'd10, 1'b1, 1'b1);

    // Reset while locked with a tick in flight.
    slow_a = !slow_a;
    repeat (2) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    check_val("mid reset outs", {rise_a, fall_a, hp_a, valid_a, locked_a, timeout_a}, 64'd0);
    slow_a  = 1'b0;
    reset_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("idle after mid reset", {rise_a, fall_a, locked_a, timeout_a}, 4'b0000);
    end

    // Let instance B see at least six edges.
    for (int i = 0; i < 40000 && b_edges < 6; i++) @(negedge clk);
    check_val("b edges seen", (b_edges >= 6), 1'b1);
    check_val("b timeouts", b_timeouts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
